// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster timing constants and the segment type shared by the
// horizontal and vertical sequencer FSMs.
package vga_timing_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   typedef enum logic [1:0] {ACT, FP, SYNC, BP} seg_t;

   function automatic int seg_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return seg_total(act, fp, sync, bp);
   endfunction

   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return seg_total(act, fp, sync, bp);
   endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Enable-gated pixel clock-enable: a registered one-clk strobe every
// DIV_VALUE+1 cycles, restarting from a fresh phase whenever enable drops.
module pixel_tick_gen #(
   parameter int DIV_VALUE = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tick
);

   localparam int DW = (DIV_VALUE > 0) ? $clog2(DIV_VALUE + 1) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV_VALUE);

   logic [DW-1:0] div_q, div_d;
   logic          tick_q, tick_d;

   always_comb begin
      div_d  = '0;
      tick_d = 1'b0;
      if (enable) begin
         if (div_q == DIV_LAST) begin
            tick_d = 1'b1;
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/vga_sync_sequencer.sv
// Raster sequencer: pixel ticks step the horizontal and vertical segment FSMs
// and position counters; syncs, visible window and line/frame markers follow.
module vga_sync_sequencer
   import vga_timing_pkg::*;
#(
   parameter int DIV_VALUE = 3,
   parameter int H_ACTIVE  = VGA_H_ACTIVE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_ACTIVE  = VGA_V_ACTIVE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP,
   parameter bit SYNC_POL  = 1'b0,
   parameter int CNT_W     = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   output logic             pix_tick,
   output logic [CNT_W-1:0] h_pos,
   output logic [CNT_W-1:0] v_pos,
   output logic             video_on,
   output logic             hsync,
   output logic             vsync,
   output logic             line_tick,
   output logic             frame_tick
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   // Last position of each segment; the FSMs leave a segment when stepping off it.
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] H_FP_END   = CNT_W'(H_ACTIVE + H_FP - 1);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_FP_END   = CNT_W'(V_ACTIVE + V_FP - 1);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);

   logic             tick;
   logic             running_q, running_d;
   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   seg_t             hseg_q, hseg_d;
   seg_t             vseg_q, vseg_d;
   logic             step;
   logic             h_wrap;

   pixel_tick_gen #(
      .DIV_VALUE (DIV_VALUE)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .tick   (tick)
   );

   assign step   = tick & running_q;
   assign h_wrap = step & (h_q == H_LAST);

   // Position counters and run flag; dropping enable returns everything to idle.
   always_comb begin
      running_d = running_q | tick;
      h_d       = h_q;
      v_d       = v_q;
      if (step) begin
         h_d = h_wrap ? '0 : h_q + CNT_W'(1);
      end
      if (h_wrap) begin
         v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end
      if (!enable) begin
         running_d = 1'b0;
         h_d       = '0;
         v_d       = '0;
      end
   end

   always_comb begin
      hseg_d = hseg_q;
      if (step) begin
         case (hseg_q)
            ACT:     if (h_q == H_ACT_END)  hseg_d = FP;
            FP:      if (h_q == H_FP_END)   hseg_d = SYNC;
            SYNC:    if (h_q == H_SYNC_END) hseg_d = BP;
            BP:      if (h_q == H_LAST)     hseg_d = ACT;
            default: hseg_d = ACT;
         endcase
      end
      if (!enable) begin
         hseg_d = ACT;
      end
   end

   always_comb begin
      vseg_d = vseg_q;
      if (h_wrap) begin
         case (vseg_q)
            ACT:     if (v_q == V_ACT_END)  vseg_d = FP;
            FP:      if (v_q == V_FP_END)   vseg_d = SYNC;
            SYNC:    if (v_q == V_SYNC_END) vseg_d = BP;
            BP:      if (v_q == V_LAST)     vseg_d = ACT;
            default: vseg_d = ACT;
         endcase
      end
      if (!enable) begin
         vseg_d = ACT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running_q <= 1'b0;
         h_q       <= '0;
         v_q       <= '0;
         hseg_q    <= ACT;
         vseg_q    <= ACT;
      end else begin
         running_q <= running_d;
         h_q       <= h_d;
         v_q       <= v_d;
         hseg_q    <= hseg_d;
         vseg_q    <= vseg_d;
      end
   end

   assign pix_tick   = tick;
   assign h_pos      = h_q;
   assign v_pos      = v_q;
   assign video_on   = running_q & (hseg_q == ACT) & (vseg_q == ACT);
   assign hsync      = (hseg_q == SYNC) ? SYNC_POL : ~SYNC_POL;
   assign vsync      = (vseg_q == SYNC) ? SYNC_POL : ~SYNC_POL;
   assign line_tick  = tick & running_q & (h_q == '0);
   assign frame_tick = line_tick & (v_q == '0);

endmodule
